// File: rtl/wm_plant_model.sv
// Washing-machine plant responder: water level, temperature,
// motor phase timing, watchdog and motor-conflict flag.
module wm_plant_model #(
  parameter int unsigned CNT_W          = 12,
  parameter int unsigned FULL_LEVEL     = 100,
  parameter int unsigned TEMP_TARGET    = 60,
  parameter int unsigned TEMP_MAX       = 90,
  parameter int unsigned COOL_DIV       = 16,
  parameter int unsigned WASH_CYCLES    = 200,
  parameter int unsigned RINSE_CYCLES   = 150,
  parameter int unsigned SPIN_CYCLES    = 100,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic fill_Water_Operation,
  input  logic water_Intake,
  input  logic heat_Water_Operation,
  input  logic wash_Operation,
  input  logic rinse_Operation,
  input  logic spin_Operation,
  input  logic fault,
  output logic sig_Full,
  output logic sig_Temperature,
  output logic sig_Wash_Completed,
  output logic sig_Rinse_Completed,
  output logic sig_Spin_Completed,
  output logic sig_Time_Out,
  output logic op_Conflict
);

  localparam int unsigned LIM = 1 << CNT_W;

  if (FULL_LEVEL >= LIM || TEMP_TARGET >= LIM ||
      TEMP_MAX >= LIM || COOL_DIV >= LIM ||
      COOL_DIV == 0 ||
      WASH_CYCLES >= LIM || RINSE_CYCLES >= LIM ||
      SPIN_CYCLES >= LIM || TIMEOUT_CYCLES >= LIM ||
      TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("wm_plant_model: parameter out of range");
  end

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t L_FULL = CNT_W'(FULL_LEVEL);
  localparam cnt_t L_TTGT = CNT_W'(TEMP_TARGET);
  localparam cnt_t L_TMAX = CNT_W'(TEMP_MAX);
  localparam cnt_t L_CDIV = CNT_W'(COOL_DIV - 1);
  localparam cnt_t L_WASH = CNT_W'(WASH_CYCLES);
  localparam cnt_t L_RNS  = CNT_W'(RINSE_CYCLES);
  localparam cnt_t L_SPIN = CNT_W'(SPIN_CYCLES);
  localparam cnt_t L_TOUT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_WASH  = 2'd1,
    OP_RINSE = 2'd2,
    OP_SPIN  = 2'd3
  } op_e;

  cnt_t       r_level, r_temp, r_div, r_cnt, r_wd;
  op_e        r_last;
  logic [4:0] r_vec;
  logic       r_to, r_conf;

  cnt_t       w_level_n, w_temp_n, w_div_n, w_cnt_n, w_wd_n;
  cnt_t       w_term;
  op_e        w_act;
  logic [4:0] w_vec;
  logic       w_conf, w_pend, w_to_n;

  assign w_vec = {fill_Water_Operation, heat_Water_Operation,
                  wash_Operation, rinse_Operation, spin_Operation};

  // Water level: drain beats fill, both saturate
  always_comb begin
    w_level_n = r_level;
    if (spin_Operation) begin
      if (r_level != '0) w_level_n = r_level - 1'b1;
    end else if (fill_Water_Operation && water_Intake) begin
      if (r_level < L_FULL) w_level_n = r_level + 1'b1;
    end
  end

  // Temperature: heat only on a full drum, slow decay when idle
  always_comb begin
    w_temp_n = r_temp;
    w_div_n  = r_div;
    if (heat_Water_Operation) begin
      if (r_level == L_FULL) begin
        w_div_n = '0;
        if (r_temp < L_TMAX) w_temp_n = r_temp + 1'b1;
      end
    end else if (r_div >= L_CDIV) begin
      w_div_n = '0;
      if (r_temp != '0) w_temp_n = r_temp - 1'b1;
    end else begin
      w_div_n = r_div + 1'b1;
    end
  end

  // Motor phase: priority pick, restart count on any change of op
  always_comb begin
    w_act  = OP_NONE;
    w_term = '0;
    if (spin_Operation) begin
      w_act  = OP_SPIN;
      w_term = L_SPIN;
    end else if (rinse_Operation) begin
      w_act  = OP_RINSE;
      w_term = L_RNS;
    end else if (wash_Operation) begin
      w_act  = OP_WASH;
      w_term = L_WASH;
    end
    w_conf = (wash_Operation & rinse_Operation) |
             (wash_Operation & spin_Operation) |
             (rinse_Operation & spin_Operation);
    if (w_act != r_last)    w_cnt_n = '0;
    else if (r_cnt < w_term) w_cnt_n = r_cnt + 1'b1;
    else                     w_cnt_n = r_cnt;
  end

  // Watchdog: counts while some commanded op is still unfinished
  always_comb begin
    w_pend = (fill_Water_Operation & ~sig_Full) |
             (heat_Water_Operation & ~sig_Temperature) |
             (wash_Operation & ~sig_Wash_Completed) |
             (rinse_Operation & ~sig_Rinse_Completed) |
             (spin_Operation & ~sig_Spin_Completed);
    w_wd_n = r_wd;
    if (w_vec == '0 || w_vec != r_vec)
      w_wd_n = '0;
    else if (w_pend && r_wd < L_TOUT)
      w_wd_n = r_wd + 1'b1;
    w_to_n = (w_wd_n == L_TOUT) && (r_wd != L_TOUT);
  end

  // State registers; fault freezes everything except reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_level <= '0;
      r_temp  <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_last  <= OP_NONE;
      r_wd    <= '0;
      r_vec   <= '0;
      r_to    <= 1'b0;
      r_conf  <= 1'b0;
    end else if (!fault) begin
      r_level <= w_level_n;
      r_temp  <= w_temp_n;
      r_div   <= w_div_n;
      r_cnt   <= w_cnt_n;
      r_last  <= w_act;
      r_wd    <= w_wd_n;
      r_vec   <= w_vec;
      r_to    <= w_to_n;
      r_conf  <= r_conf | w_conf;
    end
  end

  // Output decodes of registered state
  always_comb begin
    sig_Full            = (r_level == L_FULL);
    sig_Temperature     = (r_temp >= L_TTGT);
    sig_Wash_Completed  = (r_last == OP_WASH) && (r_cnt == L_WASH);
    sig_Rinse_Completed = (r_last == OP_RINSE) && (r_cnt == L_RNS);
    sig_Spin_Completed  = (r_last == OP_SPIN) && (r_cnt == L_SPIN);
    sig_Time_Out        = r_to;
    op_Conflict         = r_conf;
  end

endmodule

// File: tb/tb_wm_plant_model.sv
// Bench for wm_plant_model: behavioural plant model plus
// directed literal checks and randomized operation segments.
module tb_wm_plant_model;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fill = 1'b0, intake = 1'b0, heat = 1'b0;
  logic wash = 1'b0, rinse = 1'b0, spin = 1'b0, fault = 1'b0;
  logic o_full, o_temp, o_wc, o_rc, o_sc, o_to, o_conf;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wm_plant_model dut (
    .clock(clock),
    .reset(reset),
    .fill_Water_Operation(fill),
    .water_Intake(intake),
    .heat_Water_Operation(heat),
    .wash_Operation(wash),
    .rinse_Operation(rinse),
    .spin_Operation(spin),
    .fault(fault),
    .sig_Full(o_full),
    .sig_Temperature(o_temp),
    .sig_Wash_Completed(o_wc),
    .sig_Rinse_Completed(o_rc),
    .sig_Spin_Completed(o_sc),
    .sig_Time_Out(o_to),
    .op_Conflict(o_conf)
  );

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b want %b",
               nm, $time, act, exp);
    end
  endtask

  // Behavioural model of the plant
  int  m_level, m_temp, m_div, m_act, m_run, m_cnt;
  int  m_wd, m_vec;
  bit  m_to, m_conf, m_valid = 0;

  function automatic int term(input int a);
    case (a)
      1: return 200;
      2: return 150;
      3: return 100;
      default: return 0;
    endcase
  endfunction

  function automatic bit e_full();
    return m_level == 100;
  endfunction
  function automatic bit e_temp();
    return m_temp >= 60;
  endfunction
  function automatic bit e_done(input int x);
    return m_act == x && m_cnt == term(x);
  endfunction

  always @(posedge clock) begin
    int act, vec, nmot;
    bit pend;
    if (reset) begin
      m_level = 0; m_temp = 0; m_div = 0;
      m_act = 0; m_run = 1; m_cnt = 0;
      m_wd = 0; m_vec = 0; m_to = 0; m_conf = 0;
      m_valid = 1;
    end else if (!fault && m_valid) begin
      act = spin ? 3 : rinse ? 2 : wash ? 1 : 0;
      vec = {fill, heat, wash, rinse, spin};
      nmot = int'(wash) + int'(rinse) + int'(spin);
      pend = (fill && !e_full()) || (heat && !e_temp()) ||
             (wash && !e_done(1)) || (rinse && !e_done(2)) ||
             (spin && !e_done(3));
      // watchdog, using pre-edge completion state
      m_to = 0;
      if (vec == 0 || vec != m_vec) m_wd = 0;
      else if (pend && m_wd < 1000) begin
        m_wd++;
        if (m_wd == 1000) m_to = 1;
      end
      m_vec = vec;
      // temperature uses pre-edge level
      if (heat) begin
        if (m_level == 100) begin
          m_div = 0;
          if (m_temp < 90) m_temp++;
        end
      end else begin
        m_div++;
        if (m_div == 16) begin
          m_div = 0;
          if (m_temp > 0) m_temp--;
        end
      end
      if (spin) m_level = (m_level > 0) ? m_level - 1 : 0;
      else if (fill && intake)
        m_level = (m_level < 100) ? m_level + 1 : 100;
      // phase: length of the current uninterrupted run
      if (act == m_act) m_run = (m_run < 5000) ? m_run + 1 : m_run;
      else begin
        m_act = act;
        m_run = 1;
      end
      m_cnt = (m_run - 1 < term(act)) ? m_run - 1 : term(act);
      if (nmot >= 2) m_conf = 1;
    end
  end

  // Compare DUT against model every cycle, away from the edge
  always @(negedge clock) begin
    if (m_valid) begin
      chk("full", o_full, e_full());
      chk("temp", o_temp, e_temp());
      chk("wash_done", o_wc, e_done(1));
      chk("rinse_done", o_rc, e_done(2));
      chk("spin_done", o_sc, e_done(3));
      chk("timeout", o_to, m_to);
      chk("conflict", o_conf, m_conf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ops(input logic f, input logic h, input logic w,
                     input logic r, input logic s);
    fill = f; heat = h; wash = w; rinse = r; spin = s;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fault = 1'b0;
    ops(0, 0, 0, 0, 0);
    cyc(1);
    reset = 1'b0;
    chk("rst_full", o_full, 1'b0);
    chk("rst_temp", o_temp, 1'b0);
    chk("rst_wc", o_wc, 1'b0);
    chk("rst_to", o_to, 1'b0);
    chk("rst_conf", o_conf, 1'b0);
  endtask

  initial begin
    @(negedge clock);
    do_reset();

    // fill to full, then heat to target
    intake = 1'b1;
    ops(1, 0, 0, 0, 0);
    cyc(99);  chk("t1_full99", o_full, 1'b0);
    cyc(1);   chk("t1_full100", o_full, 1'b1);
    cyc(50);  chk("t1_full150", o_full, 1'b1);
    ops(0, 1, 0, 0, 0);
    cyc(59);  chk("t2_temp59", o_temp, 1'b0);
    cyc(1);   chk("t2_temp60", o_temp, 1'b1);
    cyc(100); chk("t2_temp_sat", o_temp, 1'b1);

    // dry heat at half level
    do_reset();
    ops(1, 0, 0, 0, 0);
    cyc(50);
    ops(0, 1, 0, 0, 0);
    cyc(100); chk("t2_dry", o_temp, 1'b0);

    // wash then rinse
    do_reset();
    ops(0, 0, 1, 0, 0);
    cyc(200); chk("t3_wash200", o_wc, 1'b0);
    cyc(1);   chk("t3_wash201", o_wc, 1'b1);
    cyc(20);  chk("t3_wash_hold", o_wc, 1'b1);
    ops(0, 0, 0, 1, 0);
    cyc(1);   chk("t3_wash_drop", o_wc, 1'b0);
    cyc(149); chk("t3_rinse_pre", o_rc, 1'b0);
    cyc(1);   chk("t3_rinse", o_rc, 1'b1);

    // watchdog on a fill with no supply
    do_reset();
    intake = 1'b0;
    ops(1, 0, 0, 0, 0);
    cyc(1000); chk("t4_to_pre", o_to, 1'b0);
    cyc(1);    chk("t4_to", o_to, 1'b1);
    cyc(1);    chk("t4_to_post", o_to, 1'b0);
    cyc(1998); chk("t4_no_repulse", o_to, 1'b0);
    ops(0, 0, 0, 0, 0);
    cyc(1);
    ops(1, 0, 0, 0, 0);
    cyc(1000); chk("t4_rearm_pre", o_to, 1'b0);
    cyc(1);    chk("t4_rearm", o_to, 1'b1);

    // motor conflict
    do_reset();
    intake = 1'b1;
    ops(0, 0, 1, 0, 1);
    cyc(1); chk("t5_conf", o_conf, 1'b1);
    ops(0, 0, 0, 0, 0);
    cyc(5); chk("t5_sticky", o_conf, 1'b1);

    // fault freezes the phase count, reset restarts it
    do_reset();
    ops(0, 0, 1, 0, 0);
    cyc(121);
    fault = 1'b1;
    cyc(50);
    fault = 1'b0;
    cyc(79); chk("t6_frozen", o_wc, 1'b0);
    cyc(1);  chk("t6_done", o_wc, 1'b1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    chk("t6_rst_wc", o_wc, 1'b0);
    cyc(200); chk("t6_restart_pre", o_wc, 1'b0);
    cyc(1);   chk("t6_restart", o_wc, 1'b1);

    // randomized operation segments
    for (int s = 0; s < 45; s++) begin
      int len;
      ops($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4,
          $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
          $urandom_range(0, 9) < 2);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(900, 1300)
                                        : $urandom_range(1, 260);
      for (int c = 0; c < len; c++) begin
        intake = $urandom_range(0, 9) < 8;
        fault  = $urandom_range(0, 49) == 0;
        reset  = $urandom_range(0, 999) == 0;
        cyc(1);
      end
      fault = 1'b0;
      reset = 1'b0;
    end
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
